// File: rtl/proc_pkg.sv
// Shared processor definitions for the execute-stage shifter.
//   state_t : shifter FSM encoding (IDLE / SHIFT / DONE)
//   WORD_W  : datapath word width
//   SHAMT_W : shift-amount width, clog2(WORD_W)
package proc_pkg;

  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shiftright_seq.sv
// Iterative right shifter (SRL/SRA/SRLV/SRAV), one bit per clock.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready high only in IDLE
//   in, shamt, arith    operand, shift amount (0..WIDTH-1), 1 = sign fill
//   out_valid/out_ready result handshake; result held until consumed
//   out                 shifted result (retained after handoff)
//   busy                high in SHIFT or DONE
// SHAMT_W must equal clog2(WIDTH).
module shiftright_seq
  import proc_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int SHAMT_W = proc_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               busy
);

  state_t             state;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] count;
  logic               mode;
  logic [WIDTH-1:0]   step;
  logic               accept;
  logic               last;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  // count still holds the remaining shifts, so the edge seeing 1 is the last.
  assign last     = (state == SHIFT) && (count == SHAMT_W'(1));

  // One-bit step; the current MSB is still the original sign bit.
  assign step = {mode & data[WIDTH-1], data[WIDTH-1:1]};

  // Control: state and registered out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (shamt == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand, remaining count, fill mode and the result register.
  // out only loads on completion, so it is stable in DONE and after handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
      mode  <= 1'b0;
      out   <= '0;
    end else if (accept) begin
      data  <= in;
      count <= shamt;
      mode  <= arith;
      if (shamt == '0) out <= in;
    end else if (state == SHIFT) begin
      data  <= step;
      count <= count - SHAMT_W'(1);
      if (last) out <= step;
    end
  end

endmodule

// File: tb/tb_shiftright_seq.sv
module tb_shiftright_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  shiftright_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .shamt(shamt), .arith(arith),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 1; // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: the architectural shift expression.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
    if (a) return 32'($signed(d) >>> s);
    return d >> s;
  endfunction

  // Monitor / scoreboard.
  int          acc_edge = 0;
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_out = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_edge = cyc + 1;
      if (prev_vld && !prev_rdy) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_out", out, prev_out);
      end
      if (out_valid && !prev_vld) begin
        if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - acc_edge), 32'(q[0].lat));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_handoff", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("result", out, e.data);
        end
      end
      prev_vld = out_valid;
      prev_rdy = out_ready;
      prev_out = out;
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic a);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in = d; shamt = s; arith = a;
    q.push_back('{data: ref_shift(d, int'(s), a), lat: int'(s)});
    @(posedge clk); #1;
    // Scramble inputs: the block must ignore them after accept.
    in_valid = 1'b0;
    in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in = '0; shamt = '0; arith = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner shifts.
    rdy_mode = 1;
    send(32'h8000_0000, 5'd4, 1'b1);  drain();
    send(32'h8000_0000, 5'd4, 1'b0);  drain();
    send(32'hFFFF_FFFF, 5'd31, 1'b1); drain();
    send(32'h8000_0000, 5'd31, 1'b0); drain();

    // shamt 0: busy for exactly one cycle with out_ready high.
    begin
      int bc = 0;
      send(32'h1234_5678, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
        if (busy) bc++;
        @(posedge clk); #1;
      end
      chk("busy_cycles_shamt0", 32'(bc), 32'd1);
      drain();
    end

    // Backpressure in DONE.
    begin
      int n = 0;
      rdy_mode = 0;
      @(posedge clk); #1;
      send(32'hC000_0F00, 5'd3, 1'b1);
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
      in_valid = 1'b1; in = 32'hDEAD_BEEF; shamt = 5'd1; arith = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      chk("bp_out", out, 32'hF800_01E0);
      in_valid = 1'b0;
      rdy_mode = 1;
      n = 0;
      while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
      chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
      chk("bp_retained_out", out, 32'hF800_01E0);
      chk("bp_queue_empty", 32'(q.size()), 32'd0);
    end

    // Reset during a long shift aborts it.
    send(32'hABCD_1234, 5'd20, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    chk("midrst_out", out, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_00F0, 5'd4, 1'b0);
    drain();

    // Randomised sweep with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 500; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[31] = 1'b1;
      send(d, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    rdy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
